// File: rtl/c499_sec_encoder.sv
// c499_sec_encoder
// Two-stage streaming SEC encoder for the c499 32-bit corrector.
// S1 registers the word, its injection request and 16 partial parities.
// S2 folds the partials into c0..c7, applies the one-hot injection mask
// and holds the result as the registered output word.
// S1 may only advance when S2 is empty or emitting, and there is no skid
// buffer, so in_ready depends combinationally on out_ready.

module c499_sec_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             inj_en,
  input  logic [5:0]       inj_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_check,
  output logic [CNT_W-1:0] out_count
);

  logic        s1_valid;
  logic [31:0] s1_data;
  logic        s1_inj_en;
  logic [5:0]  s1_inj_idx;
  logic [7:0]  s1_nib;
  logic [7:0]  s1_str;

  logic [7:0]  nib_c;
  logic [7:0]  str_c;
  logic [7:0]  check_c;
  logic [39:0] mask_c;
  logic [39:0] word_c;

  logic        accept;
  logic        s2_adv;
  logic        emit;

  // S2 can take a new word when it is empty or its word leaves this cycle.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;

  // Partial parities of the incoming word: nibble parities and stride-4 parities
  // within each 16-bit half.
  always_comb begin
    nib_c = '0;
    str_c = '0;
    for (int k = 0; k < 8; k++) begin
      nib_c[k] = ^in_data[4*k +: 4];
    end
    for (int j = 0; j < 4; j++) begin
      str_c[j]     = in_data[j]      ^ in_data[j+4]  ^ in_data[j+8]  ^ in_data[j+12];
      str_c[j+4]   = in_data[j+16]   ^ in_data[j+20] ^ in_data[j+24] ^ in_data[j+28];
    end
  end

  // Stage 1: capture the word, its injection request and the partial parities.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_inj_en  <= 1'b0;
      s1_inj_idx <= '0;
      s1_nib     <= '0;
      s1_str     <= '0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      s1_data    <= in_data;
      s1_inj_en  <= inj_en;
      s1_inj_idx <= inj_idx;
      s1_nib     <= nib_c;
      s1_str     <= str_c;
    end else if (s2_adv) begin
      s1_valid   <= 1'b0;
    end
  end

  // Fold partials into check bits; each check is two nibble parities plus one
  // stride parity from the opposite half.
  always_comb begin
    check_c    = '0;
    check_c[0] = s1_nib[4] ^ s1_nib[5] ^ s1_str[0];
    check_c[1] = s1_nib[6] ^ s1_nib[7] ^ s1_str[1];
    check_c[2] = s1_nib[4] ^ s1_nib[6] ^ s1_str[2];
    check_c[3] = s1_nib[5] ^ s1_nib[7] ^ s1_str[3];
    check_c[4] = s1_nib[0] ^ s1_nib[1] ^ s1_str[4];
    check_c[5] = s1_nib[2] ^ s1_nib[3] ^ s1_str[5];
    check_c[6] = s1_nib[0] ^ s1_nib[2] ^ s1_str[6];
    check_c[7] = s1_nib[1] ^ s1_nib[3] ^ s1_str[7];
  end

  // One-hot flip over {check, data}; indices 40..63 select nothing.
  always_comb begin
    mask_c = '0;
    if (s1_inj_en && (s1_inj_idx < 6'd40)) begin
      mask_c = 40'd1 << s1_inj_idx;
    end
    word_c = {check_c, s1_data} ^ mask_c;
  end

  // Stage 2: registered output word, held while the downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_check <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_check <= word_c[39:32];
        out_data  <= word_c[31:0];
      end
    end
  end

  // Emitted-word counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (emit) begin
      out_count <= out_count + 1'b1;
    end
  end

endmodule
